line_window3x3: RTL and testbench
=================================

Name: line_window3x3

Overview:
- Reader/consumer end of the line-buffer chain in the camera-to-VGA pixel path.
- Takes three row-aligned pixel taps per accepted pixel: the current line, the line delayed by one line buffer, and the line delayed by two line buffers.
- Builds a sliding 3x3 pixel window and tracks column/row position.
- Emits a window only when all nine pixels are genuine image pixels, for the downstream filter stage.

Parameters:
- Width, 12, bits per pixel (RGB444).
- IMG_width, 640, pixels per line.
- IMG_height, 480, lines per frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- pix_en  input  1  taps valid this cycle; one pixel column accepted.
- sof  input  1  start-of-frame strobe; resynchronises position counters.
- pix0  input  Width  current-line pixel (newest row).
- pix1  input  Width  one-line-delayed pixel (same column, row-1).
- pix2  input  Width  two-line-delayed pixel (same column, row-2).
- win  output  9*Width  window, slice k = win[Width*k +: Width], k = r*3+c.
  - r=0 is the pix2 row (top), r=2 is the pix0 row.
  - c=0 is the oldest column (left), c=2 is the newest column.
- win_valid  output  1  win, ctr_col and ctr_row valid this cycle.
- ctr_col  output  10  column of window centre.
- ctr_row  output  9  row of window centre.
- frame_done  output  1  one-cycle pulse: last pixel of frame accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - col and row counters go to 0; all nine window registers go to 0.
  - win, win_valid, ctr_col, ctr_row and frame_done go to 0.
  - Reset mid-frame discards all state; the next accepted pixel is (col 0, row 0).
- Accept (pix_en=1):
  - Each window row r shifts left: element c0 <= c1, c1 <= c2.
  - New c2 for r0/r1/r2 loads pix2/pix1/pix0.
  - pix_en=0: window registers, counters and all outputs except the strobes hold. win_valid and frame_done return to 0.
- Position of accepted pixel = (col,row) before increment.
  - After accept: col increments.
  - col==IMG_width-1: col wraps to 0 and row increments.
  - row==IMG_height-1 with the col wrap: row wraps to 0.
- win_valid:
  - Registered, latency 1: asserted the cycle after an accept whose position has col>=2 and row>=2; otherwise 0.
  - Windows never straddle a line boundary: the col>=2 gate excludes stale columns from the previous line.
  - First two lines are never valid because pix1/pix2 are not yet meaningful.
- ctr_col = col-1 and ctr_row = row-1 of the accepted pixel, registered together with win.
- frame_done:
  - One-cycle pulse, same cycle timing as win_valid.
  - Asserted for the accept at (IMG_width-1, IMG_height-1).
  - Coincides with the final win_valid of the frame.
- sof:
  - sof=1 with pix_en=1: the accepted pixel is forced to position (0,0); the window still shifts.
  - sof=1 with pix_en=0: counters clear to 0 and the window is untouched.
  - sof does not reset the window registers.
  - rst has priority over sof.
- Counter widths: col 10 bits, row 9 bits. Compares use full width; no overflow for the defaults.
- win_valid count per frame is exactly (IMG_width-2)*(IMG_height-2).
- No backpressure: the block accepts every pix_en cycle, including back-to-back.

Test Plan:
- Reset: hold rst 3 cycles with random pix_en/taps -> win=0, win_valid=0, frame_done=0, ctr_col=0, ctr_row=0.
- Full frame, IMG_width=4, IMG_height=3, back-to-back pix_en, pixel(r,c)=r*16+c, taps pix0=(r,c), pix1=(r-1,c), pix2=(r-2,c).
  - win_valid pulses exactly twice.
  - First pulse is the cycle after pixel (2,2): k0=0x00, k4=0x11, k8=0x22, ctr_col=1, ctr_row=1.
  - Second pulse: k0=0x01, k8=0x23, ctr_col=2.
- Same frame with pix_en low for 2 cycles between every pixel -> identical window contents and count; win_valid never high during idle cycles.
- Line boundary: at the first accept of row 2 (pixel (2,0)) and at (2,1) -> win_valid=0.
  - No window mixes columns 3 and 0.
- Frame wrap, IMG_width=4, IMG_height=3: frame_done high one cycle after pixel (2,3), together with the second win_valid.
  - Next frame's pixel is position (0,0); its win_valid count is again 2.
- sof mid-frame: assert sof with pix_en at original position (1,2) -> that pixel treated as (0,0).
  - No win_valid until the new (2,2); rst asserted at position (2,1) -> win_valid stays 0 until a fresh (2,2).

Source files
------------

// File: rtl/line_window3x3.sv
// 3x3 sliding-window builder at the consumer end of the line-buffer chain.
// Takes three row-aligned taps per accepted column and emits only fully-populated windows.
module line_window3x3 #(
  parameter int Width      = 12,
  parameter int IMG_width  = 640,
  parameter int IMG_height = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               sof,
  input  logic [Width-1:0]   pix0,
  input  logic [Width-1:0]   pix1,
  input  logic [Width-1:0]   pix2,
  output logic [9*Width-1:0] win,
  output logic               win_valid,
  output logic [9:0]         ctr_col,
  output logic [8:0]         ctr_row,
  output logic               frame_done
);

  localparam logic [9:0] COL_LAST = 10'(IMG_width - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_height - 1);

  logic [9:0]       col_q, col_d, pos_col_p0;
  logic [8:0]       row_q, row_d, pos_row_p0;
  logic [Width-1:0] win_q [9];
  logic             vld_p1_q;
  logic             fdone_p1_q;
  logic [9:0]       ctr_col_p1_q;
  logic [8:0]       ctr_row_p1_q;

  // p0: position of the pixel being accepted (sof forces it to the origin)
  always_comb begin
    pos_col_p0 = sof ? 10'd0 : col_q;
    pos_row_p0 = sof ? 9'd0  : row_q;
    col_d      = col_q;
    row_d      = row_q;
    if (pix_en) begin
      if (pos_col_p0 == COL_LAST) begin
        col_d = 10'd0;
        row_d = (pos_row_p0 == ROW_LAST) ? 9'd0 : pos_row_p0 + 9'd1;
      end else begin
        col_d = pos_col_p0 + 10'd1;
        row_d = pos_row_p0;
      end
    end else if (sof) begin
      col_d = 10'd0;
      row_d = 9'd0;
    end
  end

  // p1: shifted window and its centre position, registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= 10'd0;
      row_q        <= 9'd0;
      vld_p1_q     <= 1'b0;
      fdone_p1_q   <= 1'b0;
      ctr_col_p1_q <= 10'd0;
      ctr_row_p1_q <= 9'd0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      vld_p1_q   <= pix_en && (pos_col_p0 >= 10'd2) && (pos_row_p0 >= 9'd2);
      fdone_p1_q <= pix_en && (pos_col_p0 == COL_LAST) && (pos_row_p0 == ROW_LAST);
      if (pix_en) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r*3]     <= win_q[r*3 + 1];
          win_q[r*3 + 1] <= win_q[r*3 + 2];
        end
        win_q[2]     <= pix2;
        win_q[5]     <= pix1;
        win_q[8]     <= pix0;
        ctr_col_p1_q <= pos_col_p0 - 10'd1;
        ctr_row_p1_q <= pos_row_p0 - 9'd1;
      end
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_win
    assign win[Width*k +: Width] = win_q[k];
  end

  assign win_valid  = vld_p1_q;
  assign frame_done = fdone_p1_q;
  assign ctr_col    = ctr_col_p1_q;
  assign ctr_row    = ctr_row_p1_q;

endmodule

// File: tb/tb_line_window3x3.sv
// Bench for line_window3x3 on a 4x3 image: table-driven frames, hand sequences
// for sof/reset corners, and random traffic against a position/history model.
module tb_line_window3x3;

  localparam int W  = 12;
  localparam int IW = 4;
  localparam int IH = 3;

  logic          clk = 1'b0;
  logic          rst, pix_en, sof;
  logic [W-1:0]  pix0, pix1, pix2;
  logic [9*W-1:0] win;
  logic          win_valid, frame_done;
  logic [9:0]    ctr_col;
  logic [8:0]    ctr_row;

  line_window3x3 #(.Width(W), .IMG_width(IW), .IMG_height(IH)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .sof(sof),
    .pix0(pix0), .pix1(pix1), .pix2(pix2),
    .win(win), .win_valid(win_valid), .ctr_col(ctr_col), .ctr_row(ctr_row),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: linear pixel index within the frame plus the last three accepted columns.
  int            m_idx;
  logic [W-1:0]  m_hist [3][3];   // [column slot, 0 = oldest][row, 0 = pix2]
  logic [9*W-1:0] e_win;
  logic          e_vld, e_fd;
  logic [9:0]    e_cc;
  logic [8:0]    e_cr;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    for (int c = 0; c < 3; c++) for (int r = 0; r < 3; r++) m_hist[c][r] = '0;
    e_win = '0; e_vld = 0; e_fd = 0; e_cc = '0; e_cr = '0;
  endtask

  task automatic model_step(input logic en, input logic s, input logic rs,
                            input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2);
    int pos, c, r;
    if (rs) begin
      model_reset();
    end else if (en) begin
      pos = s ? 0 : m_idx;
      c = pos % IW;
      r = pos / IW;
      for (int k = 0; k < 2; k++) for (int q = 0; q < 3; q++) m_hist[k][q] = m_hist[k+1][q];
      m_hist[2][0] = a2; m_hist[2][1] = a1; m_hist[2][2] = a0;
      for (int q = 0; q < 3; q++) for (int k = 0; k < 3; k++) e_win[W*(q*3+k) +: W] = m_hist[k][q];
      e_vld = (c >= 2) && (r >= 2);
      e_fd  = (c == IW-1) && (r == IH-1);
      e_cc  = 10'(c - 1);
      e_cr  = 9'(r - 1);
      m_idx = (pos + 1) % (IW*IH);
    end else begin
      if (s) m_idx = 0;
      e_vld = 0;
      e_fd  = 0;
    end
  endtask

  task automatic step(input logic en, input logic s, input logic rs,
                      input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2);
    rst = rs; pix_en = en; sof = s; pix0 = a0; pix1 = a1; pix2 = a2;
    @(posedge clk);
    model_step(en, s, rs, a0, a1, a2);
    #1;
    chk("model_win", win, e_win);
    chk("model_vld", win_valid, e_vld);
    chk("model_fdone", frame_done, e_fd);
    chk("model_ctr_col", ctr_col, e_cc);
    chk("model_ctr_row", ctr_row, e_cr);
  endtask

  task automatic rstep(input logic en, input logic s, input logic rs);
    step(en, s, rs, W'($urandom), W'($urandom), W'($urandom));
  endtask

  function automatic logic [W-1:0] px(input int r, input int c);
    return (r < 0) ? '0 : W'(r*16 + c);
  endfunction

  typedef struct {
    int           r, c;
    logic         ev, efd;
    logic [W-1:0] k0, k4, k8;
    logic [9:0]   cc;
    logic [8:0]   cr;
  } vec_t;

  vec_t tbl [IW*IH];

  task automatic run_frame(input int gap, input string tag);
    int cnt = 0;
    for (int i = 0; i < IW*IH; i++) begin
      step(1'b1, 1'b0, 1'b0, px(tbl[i].r, tbl[i].c), px(tbl[i].r-1, tbl[i].c), px(tbl[i].r-2, tbl[i].c));
      chk({tag, "_vld"}, win_valid, tbl[i].ev);
      chk({tag, "_fdone"}, frame_done, tbl[i].efd);
      if (tbl[i].ev) begin
        chk({tag, "_k0"}, win[0 +: W], tbl[i].k0);
        chk({tag, "_k4"}, win[4*W +: W], tbl[i].k4);
        chk({tag, "_k8"}, win[8*W +: W], tbl[i].k8);
        chk({tag, "_ctr_col"}, ctr_col, tbl[i].cc);
        chk({tag, "_ctr_row"}, ctr_row, tbl[i].cr);
      end
      if (win_valid) cnt++;
      for (int g = 0; g < gap; g++) begin
        rstep(1'b0, 1'b0, 1'b0);
        chk({tag, "_idle_vld"}, win_valid, 1'b0);
      end
    end
    chk({tag, "_pulse_count"}, cnt, 2);
  endtask

  initial begin
    int cnt;
    rst = 1; pix_en = 0; sof = 0; pix0 = '0; pix1 = '0; pix2 = '0;
    model_reset();

    for (int i = 0; i < IW*IH; i++) begin
      tbl[i] = '{r: i / IW, c: i % IW, ev: 0, efd: 0, k0: '0, k4: '0, k8: '0, cc: '0, cr: '0};
    end
    tbl[10].ev = 1; tbl[10].k0 = 12'h000; tbl[10].k4 = 12'h011; tbl[10].k8 = 12'h022;
    tbl[10].cc = 10'd1; tbl[10].cr = 9'd1;
    tbl[11].ev = 1; tbl[11].efd = 1; tbl[11].k0 = 12'h001; tbl[11].k4 = 12'h012;
    tbl[11].k8 = 12'h023; tbl[11].cc = 10'd2; tbl[11].cr = 9'd1;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 3; i++) rstep(1'($urandom), 1'($urandom), 1'b1);
    chk("rst_win", win, '0);
    chk("rst_vld", win_valid, 1'b0);
    chk("rst_fdone", frame_done, 1'b0);
    chk("rst_ctr_col", ctr_col, 10'd0);
    chk("rst_ctr_row", ctr_row, 9'd0);

    run_frame(0, "frame_b2b");
    run_frame(2, "frame_gap");
    run_frame(0, "frame_next");

    // sof mid-frame at original position (1,2)
    rstep(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) rstep(1'b1, 1'b0, 1'b0);
    rstep(1'b1, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      rstep(1'b1, 1'b0, 1'b0);
      if (i < 10) chk("sof_early_vld", win_valid, 1'b0);
      else        chk("sof_new22_vld", win_valid, 1'b1);
    end

    // reset with pix_en at position (2,1)
    rstep(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) rstep(1'b1, 1'b0, 1'b0);
    rstep(1'b1, 1'b0, 1'b1);
    chk("rst21_vld", win_valid, 1'b0);
    chk("rst21_win", win, '0);
    for (int i = 0; i <= 10; i++) begin
      rstep(1'b1, 1'b0, 1'b0);
      if (i < 10) chk("rst21_early_vld", win_valid, 1'b0);
      else        chk("rst21_fresh22_vld", win_valid, 1'b1);
    end

    // sof while idle clears position without touching the window
    rstep(1'b0, 1'b1, 1'b0);
    rstep(1'b1, 1'b0, 1'b0);
    chk("idle_sof_ctr_col", ctr_col, 10'h3FF);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rstep(($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
